// File: rtl/svc_soc_uart_tx_fifo_if.sv
// Bus interface for the UART TX byte FIFO.
// The master side is the MMIO write strobe plus the serializer handshake.
// The slave side is the FIFO itself.
interface svc_soc_uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    // MMIO push side
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  ovf_clr;

    // serializer side
    logic                  utx_valid;
    logic [7:0]            utx_data;
    logic                  utx_ready;

    // status back to the MMIO status register
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  ovf;

    modport master (
        output wr_en,
        output wr_data,
        output ovf_clr,
        output utx_ready,
        input  utx_valid,
        input  utx_data,
        input  count,
        input  empty,
        input  full,
        input  ovf
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  ovf_clr,
        input  utx_ready,
        output utx_valid,
        output utx_data,
        output count,
        output empty,
        output full,
        output ovf
    );
endinterface

// File: rtl/svc_soc_uart_tx_fifo.sv
// UART TX byte FIFO: buffers CPU writes to the TX data register while the
// serializer is busy. First-word-fall-through with a one-cycle push-to-visible
// latency, no write-through bypass, and a sticky overflow flag for dropped
// pushes. DEPTH must be a power of two (pointers wrap by natural overflow).
module svc_soc_uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    svc_soc_uart_tx_fifo_if.slave      bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

    // storage, deliberately not reset
    logic [7:0]            mem_r [DEPTH];

    // pointers and occupancy
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_WIDTH-1:0]  count_r;

    // registered status flags
    logic                  empty_r;
    logic                  full_r;
    logic                  valid_r;
    logic                  ovf_r;

    // next-state terms
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [CNT_WIDTH-1:0]  count_nxt_s;
    logic                  ovf_nxt_s;

    // Handshake decode and next occupancy. Fullness comes from the
    // registered count, so a push into a full FIFO is dropped even when a
    // pop happens in the same cycle.
    always_comb begin
        push_s      = bus.wr_en & ~full_r;
        pop_s       = valid_r & bus.utx_ready;
        drop_s      = bus.wr_en & full_r;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_WIDTH'(1);
            2'b01:   count_nxt_s = count_r - CNT_WIDTH'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Sticky overflow: a dropped push outranks a same-cycle clear.
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Pointer, occupancy and status registers; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CNT_WIDTH{1'b0}});
            full_r  <= (count_nxt_s == CNT_WIDTH'(DEPTH));
            valid_r <= (count_nxt_s != {CNT_WIDTH{1'b0}});
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Data array write on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // Head byte is a combinational read; forced to zero while nothing is
    // valid so the uninitialised array never shows X on the port.
    assign bus.utx_data  = valid_r ? mem_r[rd_ptr_r] : 8'h00;
    assign bus.utx_valid = valid_r;
    assign bus.count     = count_r;
    assign bus.empty     = empty_r;
    assign bus.full      = full_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_svc_soc_uart_tx_fifo.sv
// Self-checking bench for the UART TX FIFO: a vector table for the basic
// push/pop sequence, hand-written sequences for overflow, wrap and async
// reset, and a byte scoreboard whose size is the reference occupancy.
module tb_svc_soc_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;

    svc_soc_uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    svc_soc_uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_total;
    int        n_pass;
    logic [7:0] sb[$];
    logic       ovf_m;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ready;
        logic       clr;
        int         exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_ovf;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock of stimulus. Called just after a rising edge; head byte and
    // valid are checked on the falling edge, status just after the next edge.
    task automatic step(input logic we, input logic [7:0] d, input logic rdy, input logic clr);
        logic       push_m;
        logic       pop_m;
        logic [7:0] exp_b;
        bus.wr_en     = we;
        bus.wr_data   = d;
        bus.utx_ready = rdy;
        bus.ovf_clr   = clr;
        @(negedge clk);
        chk("pre_valid", int'(bus.utx_valid), int'(sb.size() != 0));
        pop_m  = rdy && (sb.size() != 0);
        push_m = we && (sb.size() < DEPTH);
        if (pop_m) begin
            exp_b = sb.pop_front();
            chk("pop_data", int'(bus.utx_data), int'(exp_b));
        end
        if (push_m) begin
            sb.push_back(d);
        end
        if (we && !push_m) begin
            ovf_m = 1'b1;
        end else if (clr) begin
            ovf_m = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.utx_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        chk("count", int'(bus.count), sb.size());
        chk("empty", int'(bus.empty), int'(sb.size() == 0));
        chk("full",  int'(bus.full),  int'(sb.size() == DEPTH));
        chk("ovf",   int'(bus.ovf),   int'(ovf_m));
        chk("valid", int'(bus.utx_valid), int'(sb.size() != 0));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        ovf_m   = 1'b0;

        // basic push then drain; expected state after each edge
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.utx_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full",  int'(bus.full),  0);
        chk("rst_valid", int'(bus.utx_valid), 0);
        chk("rst_ovf",   int'(bus.ovf),   0);

        // table: three pushes, then drain and an ignored ready on empty
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].wr_en, vecs[i].wr_data, vecs[i].ready, vecs[i].clr);
            chk("tbl_count", int'(bus.count), vecs[i].exp_count);
            chk("tbl_empty", int'(bus.empty), int'(vecs[i].exp_empty));
            chk("tbl_full",  int'(bus.full),  int'(vecs[i].exp_full));
            chk("tbl_ovf",   int'(bus.ovf),   int'(vecs[i].exp_ovf));
            chk("tbl_valid", int'(bus.utx_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk("tbl_head", int'(bus.utx_data), int'(vecs[i].exp_data));
            end
        end

        // 17 pushes into a 16-deep FIFO: last one dropped, ovf set
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
        end
        chk("t3_full",  int'(bus.full),  1);
        chk("t3_count", int'(bus.count), 16);
        chk("t3_ovf",   int'(bus.ovf),   1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t3_empty", int'(bus.empty), 1);
        chk("t3_ovf_kept", int'(bus.ovf), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_ovf_clr", int'(bus.ovf), 0);

        // full FIFO with push and pop in the same cycle: push still dropped
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        end
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("t4_count", int'(bus.count), 15);
        chk("t4_ovf",   int'(bus.ovf),   1);
        step(1'b1, 8'h90, 1'b0, 1'b1);
        chk("t4_refull", int'(bus.full), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_clr_alone", int'(bus.ovf), 0);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("t4_set_wins", int'(bus.ovf), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_clr_final", int'(bus.ovf), 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t4_empty", int'(bus.empty), 1);

        // streaming push+pop for 40 cycles: occupancy stays at 1, pointers wrap
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            chk("t5_count_const", int'(bus.count), 1);
            chk("t5_head", int'(bus.utx_data), i);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_empty", int'(bus.empty), 1);

        // asynchronous reset between edges with five bytes held
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        end
        chk("t6_pre_count", int'(bus.count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", int'(bus.utx_valid), 0);
        chk("t6_count", int'(bus.count), 0);
        chk("t6_empty", int'(bus.empty), 1);
        chk("t6_ovf",   int'(bus.ovf),   0);
        sb.delete();
        ovf_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("t6_after_head", int'(bus.utx_data), 8'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
